hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Producer of pipeline stall and flush controls for the 5-stage RV32I core.
- Companion to the forwarding logic: handles the data hazards that forwarding cannot cover (load-use, load-to-branch-in-ID) and taken-branch flushes in ID.
- Freezes the whole pipeline while a data-memory access waits on its req/ack handshake.
- Keeps a wait-timeout error flag and a saturating stall-cycle counter.

Parameters:
- NB_OPERAND, 5, register index width
- MAX_MEM_WAIT, 64, number of MEM_WAIT cycles after which the timeout flag is set
- NB_STALL_CNT, 16, width of the stall-cycle counter

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_if_id_rs1 / i_if_id_rs2  in  NB_OPERAND  source registers of the instruction in ID
- i_if_id_use_rs1 / i_if_id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- i_if_id_is_branch  in  1  ID instruction is a branch or JALR, resolved in ID
- i_branch_taken  in  1  ID branch/jump resolved taken this cycle
- i_id_ex_rd  in  NB_OPERAND  destination register in EX
- i_id_ex_rf_write  in  1  EX instruction writes the register file
- i_id_ex_mem_read  in  1  EX instruction is a load
- i_ex_mem_rd  in  NB_OPERAND  destination register in MEM
- i_ex_mem_mem_read  in  1  MEM instruction is a load
- i_dmem_req  in  1  MEM stage is issuing a data-memory access
- i_dmem_ack  in  1  data memory completes the access this cycle
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID register load enable
- o_if_id_flush  out  1  IF/ID register is cleared to a NOP
- o_id_ex_bubble  out  1  ID/EX register loads a NOP
- o_pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB registers hold their contents
- o_mem_timeout  out  1  sticky: a memory wait reached MAX_MEM_WAIT cycles
- o_stall_cycles  out  NB_STALL_CNT  saturating count of cycles with o_pc_write=0

Behaviour:
- Reset is asynchronous, active-low. On assertion:
  - FSM goes to RUN; rst_done=0; wait counter=0; o_mem_timeout=0; o_stall_cycles=0.
- rst_done is a register that goes to 1 on the first i_clk edge after reset release.
  - While rst_done=0: o_pc_write=0, o_if_id_write=0, o_if_id_flush=0, o_id_ex_bubble=0, o_pipe_hold=1.
  - The stall counter does not count while rst_done=0.
- A register "matches" only when it is nonzero, equal to the compared register, and the corresponding use_rsN=1.
- load_use = i_id_ex_mem_read && i_id_ex_rd matches rs1 or rs2.
- branch_load = i_if_id_is_branch && i_ex_mem_mem_read && i_ex_mem_rd matches rs1 or rs2.
  - A load in EX ahead of a branch therefore stalls 2 cycles: load_use, then branch_load.
- branch_alu = i_if_id_is_branch && i_id_ex_rf_write && !i_id_ex_mem_read && rd matches → no stall (covered by forwarding).
- FSM states:
  - RUN → MEM_WAIT when i_dmem_req && !i_dmem_ack.
  - MEM_WAIT → RUN on i_dmem_ack.
  - RUN holds when i_dmem_req && i_dmem_ack (zero-wait access).
- Output priority, combinational from state and inputs (rst_done=1):
  1. Memory wait: (MEM_WAIT && !i_dmem_ack) or (RUN && i_dmem_req && !i_dmem_ack) → pc_write=0, if_id_write=0, pipe_hold=1, bubble=0, flush=0.
  2. Data stall: load_use or branch_load → pc_write=0, if_id_write=0, bubble=1, pipe_hold=0, flush=0.
  3. i_branch_taken (only honoured here) → pc_write=1, if_id_write=1, flush=1.
  4. Otherwise → pc_write=1, if_id_write=1, all others 0.
- The ack cycle itself is not a memory stall; the pipeline advances that cycle.
- Wait counter:
  - Increments each cycle in MEM_WAIT; cleared on entry to RUN; saturates at MAX_MEM_WAIT.
  - When it reaches MAX_MEM_WAIT, o_mem_timeout is set and remains set until reset.
  - The FSM keeps waiting; there is no abort.
- o_stall_cycles increments by 1 on each clock edge where o_pc_write was 0 and rst_done=1; it holds at all-ones.
- A reset during MEM_WAIT returns the FSM to RUN; a pending ack is ignored.

Test Plan:
- Reset release with all inputs 0 → first cycle pc_write=0, pipe_hold=1; from the second cycle pc_write=1, if_id_write=1, stall count stays 0.
- EX load, rd=5; ID add with rs2=5, use_rs2=1 → one cycle of pc_write=0 and bubble=1, then normal; o_stall_cycles=1.
- EX load, rd=7; ID beq with rs1=7 → two stall cycles (load_use, then branch_load); i_branch_taken=1 in the third cycle → flush=1 for one cycle; count=2.
- Load with rd=0 in EX, ID uses rs1=0 → no stall; bubble stays 0.
- i_dmem_req=1, ack after 3 cycles, concurrent load_use → pipe_hold=1 and bubble=0 for 3 cycles, then load_use bubble; timeout stays 0.
- MAX_MEM_WAIT=4, ack withheld 10 cycles → o_mem_timeout=1 after the 4th wait cycle, stays set after ack; a mid-wait reset clears it and the FSM returns to RUN.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control for the 5-stage RV32I pipeline.
// Covers the data hazards forwarding cannot resolve (load-use and
// load-to-branch-in-ID), honours taken-branch flushes resolved in ID, and
// freezes the whole pipeline while a data-memory access waits for its ack.
// Also keeps a sticky memory-wait timeout flag and a saturating counter of
// cycles in which the PC was not updated.
module hazard_unit #(
  parameter int NB_OPERAND   = 5,
  parameter int MAX_MEM_WAIT = 64,
  parameter int NB_STALL_CNT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NB_OPERAND-1:0]   i_if_id_rs1,
  input  logic [NB_OPERAND-1:0]   i_if_id_rs2,
  input  logic                    i_if_id_use_rs1,
  input  logic                    i_if_id_use_rs2,
  input  logic                    i_if_id_is_branch,
  input  logic                    i_branch_taken,
  input  logic [NB_OPERAND-1:0]   i_id_ex_rd,
  input  logic                    i_id_ex_rf_write,
  input  logic                    i_id_ex_mem_read,
  input  logic [NB_OPERAND-1:0]   i_ex_mem_rd,
  input  logic                    i_ex_mem_mem_read,
  input  logic                    i_dmem_req,
  input  logic                    i_dmem_ack,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_bubble,
  output logic                    o_pipe_hold,
  output logic                    o_mem_timeout,
  output logic [NB_STALL_CNT-1:0] o_stall_cycles
);

  localparam int NB_WAIT = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [NB_WAIT-1:0] WAIT_MAX = NB_WAIT'(MAX_MEM_WAIT);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]              state_reg, state_next;
  logic                    rst_done_reg;
  logic [NB_WAIT-1:0]      wait_cnt_reg, wait_cnt_next;
  logic                    timeout_reg, timeout_next;
  logic [NB_STALL_CNT-1:0] stall_cnt_reg, stall_cnt_next;

  // Per-source hazard detection: index 0 is rs1, index 1 is rs2.
  logic [NB_OPERAND-1:0] src_rs [2];
  logic [1:0]            src_use;
  logic [1:0]            ex_match;
  logic [1:0]            mem_match;

  assign src_rs[0]  = i_if_id_rs1;
  assign src_rs[1]  = i_if_id_rs2;
  assign src_use[0] = i_if_id_use_rs1;
  assign src_use[1] = i_if_id_use_rs2;

  // x0 never creates a dependency, and an operand the instruction does not
  // read must not stall it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_match[gi]  = src_use[gi] && (src_rs[gi] != '0) &&
                             (src_rs[gi] == i_id_ex_rd);
      assign mem_match[gi] = src_use[gi] && (src_rs[gi] != '0) &&
                             (src_rs[gi] == i_ex_mem_rd);
    end
  endgenerate

  logic load_use;
  logic branch_load;
  logic branch_alu;
  logic data_stall;
  logic mem_stall;

  assign load_use    = i_id_ex_mem_read && (|ex_match);
  assign branch_load = i_if_id_is_branch && i_ex_mem_mem_read && (|mem_match);
  // An ALU result in EX feeding a branch in ID is handled by the forwarding
  // path, so it never stalls; it is only decoded here for visibility.
  assign branch_alu  = i_if_id_is_branch && i_id_ex_rf_write &&
                       !i_id_ex_mem_read && (|ex_match);
  assign data_stall  = load_use || branch_load;

  logic unused_branch_alu;
  assign unused_branch_alu = branch_alu;

  // The ack cycle itself is not a wait: the pipeline advances on it.
  assign mem_stall = ((state_reg == ST_MEM_WAIT) && !i_dmem_ack) ||
                     ((state_reg == ST_RUN) && i_dmem_req && !i_dmem_ack);

  // Memory handshake FSM: leave RUN only when a request is not acked at once.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:      if (i_dmem_req && !i_dmem_ack) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (i_dmem_ack)                state_next = ST_RUN;
      default:                                    state_next = ST_RUN;
    endcase
  end

  // Wait counter counts MEM_WAIT cycles, saturates, and clears back in RUN;
  // the timeout flag latches the moment the count reaches the limit.
  always_comb begin
    wait_cnt_next = '0;
    if ((state_reg == ST_MEM_WAIT) && !i_dmem_ack) begin
      if (wait_cnt_reg < WAIT_MAX) wait_cnt_next = wait_cnt_reg + NB_WAIT'(1);
      else                         wait_cnt_next = wait_cnt_reg;
    end
    timeout_next = timeout_reg || (wait_cnt_next == WAIT_MAX);
  end

  // Pipeline control outputs, highest priority first: reset warm-up,
  // memory freeze, data-hazard bubble, branch flush, normal advance.
  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_hold    = 1'b0;
    if (!rst_done_reg) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_pipe_hold   = 1'b1;
    end else if (mem_stall) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_pipe_hold   = 1'b1;
    end else if (data_stall) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_branch_taken) begin
      o_if_id_flush = 1'b1;
    end
  end

  // Stall counter: one count per post-reset cycle without a PC update.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (rst_done_reg && !o_pc_write && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + NB_STALL_CNT'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_RUN;
      rst_done_reg  <= 1'b0;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rst_done_reg  <= 1'b1;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign o_mem_timeout  = timeout_reg;
  assign o_stall_cycles = stall_cnt_reg;

endmodule
